// File: rtl/mp_addsub_if.sv
// Start/done handshake bundle between the Montgomery controller and mp_addsub.
// The controller side is the master; the adder/subtractor is the slave.
interface mp_addsub_if #(
  parameter int unsigned WIDTH = 1024
);
  logic             start;
  logic             subtract;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   c;
  logic             done;
  logic             busy;

  modport master (
    output start, subtract, a, b,
    input  c, done, busy
  );

  modport slave (
    input  start, subtract, a, b,
    output c, done, busy
  );
endinterface

// File: rtl/mp_addsub.sv
// Multi-precision adder/subtractor: one LIMB-bit slice per cycle through a single
// LIMB-bit adder. Result c = {carry/borrow, sum/difference}, updated only when an
// operation completes. WIDTH must be a positive multiple of LIMB.
module mp_addsub #(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned LIMB  = 64
) (
  input logic        clk,
  input logic        rst,
  mp_addsub_if.slave bus
);

  localparam int unsigned NumLimbs = WIDTH / LIMB;
  localparam int unsigned CntW     = $clog2(NumLimbs + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumLimbs - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH:0]   c_q;
  logic             sub_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;

  logic [LIMB:0]    limb_sum;
  logic [WIDTH-1:0] acc_shift;

  // Shared limb adder; subtract is A + ~B + 1 with the +1 preloaded into carry_q.
  always_comb begin
    limb_sum  = {1'b0, a_q[LIMB-1:0]}
              + {1'b0, b_q[LIMB-1:0] ^ {LIMB{sub_q}}}
              + {{LIMB{1'b0}}, carry_q};
    // New limb enters at the top; also valid when NumLimbs == 1.
    acc_shift = WIDTH'({limb_sum[LIMB-1:0], acc_q} >> LIMB);
  end

  // Control FSM and datapath registers; c_q only moves on the final limb.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= bus.subtract;
            carry_q <= bus.subtract;
            cnt_q   <= '0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q     <= a_q >> LIMB;
          b_q     <= b_q >> LIMB;
          acc_q   <= acc_shift;
          carry_q <= limb_sum[LIMB];
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            // Subtract: top bit is borrow = NOT carry-out.
            c_q     <= {sub_q ^ limb_sum[LIMB], acc_shift};
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Status decoded purely from the state register.
  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.c    = c_q;

endmodule

// File: tb/tb_mp_addsub.sv
// Scoreboard bench for mp_addsub: three configurations (1024/64, 128/32, 64/64).
// Stimulus pushes expected results; per-instance monitors pop them on done.
module tb_mp_addsub;

  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  always #5 clk = ~clk;

  mp_addsub_if #(.WIDTH(1024)) bus0 ();
  mp_addsub_if #(.WIDTH(128))  bus1 ();
  mp_addsub_if #(.WIDTH(64))   bus2 ();

  mp_addsub #(.WIDTH(1024), .LIMB(64)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  mp_addsub #(.WIDTH(128),  .LIMB(32)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  mp_addsub #(.WIDTH(64),   .LIMB(64)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  int checks = 0;
  int errors = 0;

  logic [1024:0] q0[$];
  logic [1024:0] q1[$];
  logic [1024:0] q2[$];

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reports the lowest differing 64-bit limb to keep lines short.
  task automatic chk_vec(input string name, input logic [1024:0] act, input logic [1024:0] exp);
    checks++;
    if (act !== exp) begin
      int j = 0;
      errors++;
      for (int i = 15; i >= 0; i--) if (act[i*64 +: 64] !== exp[i*64 +: 64]) j = i;
      $display("FAIL %s: limb %0d got %h expected %h, top bit got %b expected %b",
               name, j, act[j*64 +: 64], exp[j*64 +: 64], act[1024], exp[1024]);
    end
  endtask

  function automatic logic [1024:0] ref_model(input logic sub, input logic [1023:0] a,
                                              input logic [1023:0] b);
    if (sub) return {a < b, a - b};
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic drive(input int idx, input logic s, input logic sub,
                       input logic [1023:0] a, input logic [1023:0] b);
    case (idx)
      0: begin bus0.start = s; bus0.subtract = sub; bus0.a = a;         bus0.b = b;         end
      1: begin bus1.start = s; bus1.subtract = sub; bus1.a = a[127:0];  bus1.b = b[127:0];  end
      default: begin
         bus2.start = s; bus2.subtract = sub; bus2.a = a[63:0]; bus2.b = b[63:0];
      end
    endcase
  endtask

  function automatic logic get_busy(input int idx);
    case (idx)
      0: return bus0.busy;
      1: return bus1.busy;
      default: return bus2.busy;
    endcase
  endfunction

  function automatic logic get_done(input int idx);
    case (idx)
      0: return bus0.done;
      1: return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  function automatic logic [1024:0] get_c(input int idx);
    case (idx)
      0: return bus0.c;
      1: return 1025'(bus1.c);
      default: return 1025'(bus2.c);
    endcase
  endfunction

  // One operation; lat is the cycle (counted from the start edge) holding done.
  task automatic run_op(input string name, input int idx, input logic sub,
                        input logic [1023:0] a, input logic [1023:0] b,
                        input logic [1024:0] exp, input int lat);
    int busy_n = 0;
    int done_k = 0;
    bit glitch = (lat > 3);
    case (idx)
      0: q0.push_back(exp);
      1: q1.push_back(exp);
      default: q2.push_back(exp);
    endcase
    @(negedge clk);
    drive(idx, 1'b1, sub, a, b);
    for (int k = 1; k <= 200 && done_k == 0; k++) begin
      @(negedge clk);
      if (get_busy(idx)) busy_n++;
      if (get_done(idx)) done_k = k;
      if (k == 1) drive(idx, 1'b0, sub, a, b);
      // Stray start with different mode/operands while busy must be ignored.
      if (k == 2 && glitch) drive(idx, 1'b1, ~sub, ~a, ~b);
      if (k == 3 && glitch) drive(idx, 1'b0, sub, a, b);
    end
    chk_int({name, "_done_cycle"}, done_k, lat);
    chk_int({name, "_busy_cycles"}, busy_n, lat - 1);
    @(negedge clk);
    chk_int({name, "_done_pulse_len"}, int'(get_done(idx)), 0);
    chk_int({name, "_idle_busy"}, int'(get_busy(idx)), 0);
  endtask

  // Monitors: compare c against the scoreboard whenever done is presented.
  always @(negedge clk) begin
    if (bus0.done) begin
      chk_int("q0_expected_at_done", int'(q0.size() > 0), 1);
      if (q0.size() > 0) chk_vec("c0", bus0.c, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (bus1.done) begin
      chk_int("q1_expected_at_done", int'(q1.size() > 0), 1);
      if (q1.size() > 0) chk_vec("c1", 1025'(bus1.c), q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (bus2.done) begin
      chk_int("q2_expected_at_done", int'(q2.size() > 0), 1);
      if (q2.size() > 0) chk_vec("c2", 1025'(bus2.c), q2.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] ones;
    logic [1023:0] av;
    logic [1023:0] ra;
    logic [1023:0] rb;
    logic          rsub;
    int            k;

    ones = '1;
    av   = 1024'h0123456789ABCDEF_FEDCBA9876543210;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_vec($sformatf("reset_c%0d", i), get_c(i), '0);
      chk_int($sformatf("reset_done%0d", i), int'(get_done(i)), 0);
      chk_int($sformatf("reset_busy%0d", i), int'(get_busy(i)), 0);
    end
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // 1024/64: carry ripples through all 16 limbs into the top bit.
    run_op("add_max", 0, 1'b0, ones, 1024'd1, {1'b1, 1024'd0}, 17);
    // 5 - 7: borrow set, difference 2^1024 - 2.
    run_op("sub_neg", 0, 1'b1, 1024'd5, 1024'd7, {1'b1, ~1024'd1}, 17);

    // 128/32.
    run_op("sub_eq", 1, 1'b1, av, av, '0, 5);
    run_op("add_dbl", 1, 1'b0, av, av,
           1025'h0_02468ACF13579BDF_FDB97530ECA86420, 5);
    run_op("sub_pos", 1, 1'b1, 1024'd10, 1024'd3, 1025'd7, 5);
    run_op("add_limb_carry", 1, 1'b0, 1024'hFFFF_FFFF, 1024'd1, 1025'h1_0000_0000, 5);

    // 64/64: single-limb instance.
    run_op("n1_add", 2, 1'b0, 1024'h8000_0000_0000_0000, 1024'h8000_0000_0000_0000,
           1025'h1_0000_0000_0000_0000, 2);
    run_op("n1_sub", 2, 1'b1, 1024'd1, 1024'd2, 1025'h1_FFFF_FFFF_FFFF_FFFF, 2);

    // Abort: reset during cycle 3 of a 16-limb run; no done may follow.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, ones, ones);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, ones, ones);
    @(negedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    chk_vec("abort_c", bus0.c, '0);
    chk_int("abort_busy", int'(bus0.busy), 0);
    chk_int("abort_done", int'(bus0.done), 0);
    repeat (25) @(negedge clk);
    chk_int("abort_stays_idle", int'(bus0.busy), 0);

    // Back-to-back with start held: new operands presented in each done cycle.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 32; w++) begin
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      rsub = (i % 2) == 1;
      q0.push_back(ref_model(rsub, ra, rb));
      drive(0, 1'b1, rsub, ra, rb);
      k = 0;
      for (int c = 1; c <= 100 && k == 0; c++) begin
        @(negedge clk);
        if (bus0.done) k = c;
      end
      chk_int($sformatf("b2b_period_%0d", i), k, 17);
    end
    drive(0, 1'b0, 1'b0, '0, '0);

    repeat (4) @(negedge clk);
    chk_int("q0_drained", q0.size(), 0);
    chk_int("q1_drained", q1.size(), 0);
    chk_int("q2_drained", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
